// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter feeding one RS232 TX engine from NREQ byte producers; RS232_ARB_LOCK_EN enables frame locking.
// Latency: byte accepted in cycle T is offered to TX from T+1; GAP idle cycles follow each TX handshake.
// Backpressure: req_ready stays low while a byte is held for TX or the gap runs; tx_ready low holds tx_data.
module rs232_tx_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int GAP  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NREQ-1:0]    req_valid_i,
    input  logic [NREQ*DW-1:0] req_data_i,
    input  logic [NREQ-1:0]    req_last_i,
    output logic [NREQ-1:0]    req_ready_o,
    output logic               tx_valid_o,
    output logic [DW-1:0]      tx_data_o,
    input  logic               tx_ready_i,
    output logic [NREQ-1:0]    grant_o,
    output logic               busy_o
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] GAP_LD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

`ifdef RS232_ARB_LOCK_EN
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_OWN} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
`endif

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [7:0]      gap_cnt_q;
    logic            tx_valid_q;
    logic [DW-1:0]   tx_data_q;
    logic [NREQ-1:0] grant_q;
    logic            busy_q;

    logic [PW-1:0]   cand;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   sel_idx;
    logic            win_vld;
    logic            own_vld;
    logic            sel_vld;
    logic [DW-1:0]   sel_data;
    logic            sel_last;
    state_t          arb_state;
    logic            arb_busy;

    // Scan from farthest to nearest so the requester closest after ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (req_valid_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        own_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (ptr_q == PW'(i)) begin
                own_vld = req_valid_i[i];
            end
        end
    end

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = win_idx;
        if (!rst_i) begin
            case (state_q)
                S_IDLE: sel_vld = win_vld;
`ifdef RS232_ARB_LOCK_EN
                S_OWN: begin
                    sel_vld = own_vld;
                    sel_idx = ptr_q;
                end
`endif
                default: sel_vld = 1'b0;
            endcase
        end
    end

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready_o[i] = sel_vld && (sel_idx == PW'(i));
            if (sel_idx == PW'(i)) begin
                sel_data = req_data_i[i*DW +: DW];
                sel_last = req_last_i[i];
            end
        end
    end

`ifdef RS232_ARB_LOCK_EN
    logic lock_q;
    always_comb begin
        arb_state = lock_q ? S_OWN : S_IDLE;
        arb_busy  = lock_q;
    end
`else
    logic unused_last;
    assign unused_last = sel_last ^ own_vld;
    assign arb_state   = S_IDLE;
    assign arb_busy    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(NREQ - 1);
            gap_cnt_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
`ifdef RS232_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
`ifdef RS232_ARB_LOCK_EN
                S_IDLE, S_OWN: begin
`else
                S_IDLE: begin
`endif
                    if (sel_vld) begin
                        tx_data_q  <= sel_data;
                        tx_valid_q <= 1'b1;
                        grant_q    <= req_ready_o;
                        ptr_q      <= sel_idx;
                        busy_q     <= 1'b1;
                        state_q    <= S_SEND;
`ifdef RS232_ARB_LOCK_EN
                        lock_q     <= ~sel_last;
`endif
                    end
                end
                S_SEND: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        if (GAP > 0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= GAP_LD;
                        end else begin
                            state_q <= arb_state;
                            busy_q  <= arb_busy;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q <= arb_state;
                        busy_q  <= arb_busy;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign grant_o    = grant_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Randomized and directed bench for rs232_tx_arbiter with a timestamp-based reference model and TX scoreboard.
module tb_rs232_tx_arbiter;
    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int GAP   = 2;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               tx_valid;
    logic [DW-1:0]      tx_data;
    logic               tx_ready;
    logic [NREQ-1:0]    grant;
    logic               busy;

    rs232_tx_arbiter #(.NREQ(NREQ), .DW(DW), .GAP(GAP)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Producer byte buffers: {last, data} per requester
    logic [DW:0]     pbuf [NREQ][DEPTH];
    int              phead [NREQ];
    int              ptail [NREQ];
    logic [NREQ-1:0] hold;
    int              dcyc = 0;
    int              acc_cyc[$];

    function automatic int pcount(input int i);
        return ptail[i] - phead[i];
    endfunction

    task automatic push(input int i, input logic last, input logic [DW-1:0] d);
        pbuf[i][ptail[i] % DEPTH] = {last, d};
        ptail[i]++;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            logic [DW:0] e;
            e = pbuf[i][phead[i] % DEPTH];
            req_valid[i]         = (pcount(i) > 0) && !hold[i];
            req_last[i]          = (pcount(i) > 0) ? e[DW] : 1'b0;
            req_data[i*DW +: DW] = (pcount(i) > 0) ? e[DW-1:0] : DW'($urandom);
        end
    endtask

    task automatic cyc();
        logic [NREQ-1:0] acc;
        drive();
        @(negedge clk);
        acc = req_valid & req_ready;
        if (acc != '0) acc_cyc.push_back(dcyc);
        @(posedge clk);
        #2;
        for (int i = 0; i < NREQ; i++) if (acc[i]) phead[i]++;
        dcyc++;
    endtask

    // Reference model: a byte is owed to TX after acceptance; after its
    // handshake at cycle S nothing may be accepted before S+1+GAP.
    logic [DW-1:0]   eq_data[$];
    int              eq_idx[$];
    bit              m_pend    = 1'b0;
    int              m_allowed = 0;
    int              m_ptr     = NREQ - 1;
    int              m_lock    = -1;
    logic [NREQ-1:0] m_grant   = '0;
    logic [DW-1:0]   m_data    = '0;
    int              mcyc      = 0;

    always @(negedge clk) begin : model_p
        logic [NREQ-1:0] exp_rdy;
        int w;
        int j;
        bit m_busy;
        exp_rdy = '0;
        w = -1;
        m_busy = m_pend || (mcyc < m_allowed) || (m_lock >= 0);
        chk("tx_valid", int'(tx_valid), int'(m_pend));
        chk("grant", int'(grant), int'(m_grant));
        chk("tx_data", int'(tx_data), int'(m_data));
        chk("busy", int'(busy), int'(m_busy));
        if (rst) begin
            m_pend = 1'b0; m_allowed = 0; m_ptr = NREQ - 1; m_lock = -1;
            m_grant = '0; m_data = '0;
            eq_data.delete(); eq_idx.delete();
        end else if (m_pend) begin
            if (tx_ready) begin
                m_pend = 1'b0;
                m_allowed = mcyc + 1 + GAP;
            end
        end else if (mcyc >= m_allowed) begin
            if (m_lock >= 0) begin
                if (req_valid[m_lock]) w = m_lock;
            end else begin
                for (int k = 1; k <= NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (w < 0 && req_valid[j]) w = j;
                end
            end
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                eq_data.push_back(req_data[w*DW +: DW]);
                eq_idx.push_back(w);
                m_ptr = w;
                m_grant = NREQ'(1) << w;
                m_data = req_data[w*DW +: DW];
                m_pend = 1'b1;
`ifdef RS232_ARB_LOCK_EN
                m_lock = req_last[w] ? -1 : w;
`endif
            end
        end
        chk("req_ready", int'(req_ready), int'(exp_rdy));
        mcyc++;
    end

    logic [DW-1:0] log_q[$];
    int hs_cnt = 0;

    always @(negedge clk) begin : mon_p
        if (!rst && tx_valid && tx_ready) begin
            hs_cnt++;
            log_q.push_back(tx_data);
            if (eq_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
            end else begin
                logic [DW-1:0] ed;
                int ei;
                ed = eq_data.pop_front();
                ei = eq_idx.pop_front();
                chk("tx_byte", int'(tx_data), int'(ed));
                chk("tx_grant", int'(grant), 1 << ei);
            end
        end
    end

    function automatic bit all_idle();
        for (int i = 0; i < NREQ; i++) if (pcount(i) != 0) return 1'b0;
        return (eq_data.size() == 0) && !tx_valid;
    endfunction

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && !all_idle()) begin
            cyc();
            n++;
        end
        chk("drain_done", int'(all_idle()), 1);
        repeat (GAP + 2) cyc();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tx_ready = 1'b0;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    task automatic chk_log(input string name, input int exp[5]);
        chk({name, "_count"}, log_q.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < log_q.size()) chk(name, int'(log_q[k]), exp[k]);
    endtask

    int exp_rr[5]   = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
`ifdef RS232_ARB_LOCK_EN
    int exp_lock[5] = '{'h11, 'h12, 'h13, 'h01, 'h02};
`else
    int exp_lock[5] = '{'h11, 'h01, 'h12, 'h02, 'h13};
`endif

    initial begin
        int start;
        int n;
        for (int i = 0; i < NREQ; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        hold = '0; req_valid = '0; req_data = '0; req_last = '0;
        rst = 1'b1; tx_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (20) cyc();

        // single requester, gap spacing
        tx_ready = 1'b1;
        acc_cyc.delete(); log_q.delete();
        push(2, 1'b1, 8'h5A);
        push(2, 1'b1, 8'h5B);
        run_until_idle(60);
        chk("gap_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk("gap_spacing", acc_cyc[1] - acc_cyc[0], GAP + 2);
        chk("single_first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'h5A);

        // all requesters valid, round-robin order
        do_reset(2);
        tx_ready = 1'b1;
        log_q.delete();
        push(0, 1'b1, 8'hA0); push(0, 1'b1, 8'hA0);
        push(1, 1'b1, 8'hA1); push(2, 1'b1, 8'hA2); push(3, 1'b1, 8'hA3);
        run_until_idle(100);
        chk_log("rr_order", exp_rr);

        // TX backpressure
        log_q.delete();
        tx_ready = 1'b0;
        push(1, 1'b1, 8'h77); push(2, 1'b1, 8'h88);
        start = hs_cnt;
        repeat (10) cyc();
        chk("bp_no_handshake", hs_cnt - start, 0);
        chk("bp_tx_valid_held", int'(tx_valid), 1);
        tx_ready = 1'b1;
        cyc();
        chk("bp_done_on_ready", hs_cnt - start, 1);
        run_until_idle(60);
        chk("bp_first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'h77);
        chk("bp_second", (log_q.size() > 1) ? int'(log_q[1]) : -1, 'h88);

        // reset while a byte waits in SEND
        tx_ready = 1'b0;
        push(3, 1'b1, 8'h33);
        n = 0;
        while (pcount(3) > 0 && n < 10) begin
            cyc();
            n++;
        end
        chk("rst_byte_accepted", pcount(3), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_grant_cleared", int'(grant), 0);
        chk("rst_tx_valid_low", int'(tx_valid), 0);
        log_q.delete();
        tx_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) push(i, 1'b1, DW'(8'hC0 + i));
        run_until_idle(100);
        chk("rst_after_count", log_q.size(), NREQ);
        chk("rst_after_first", (log_q.size() > 0) ? int'(log_q[0]) : -1, 'hC0);

        // frame lock vs plain rotation
        do_reset(2);
        tx_ready = 1'b1;
        log_q.delete();
        push(1, 1'b0, 8'h11); push(1, 1'b0, 8'h12); push(1, 1'b1, 8'h13);
        n = 0;
        while (pcount(1) > 2 && n < 10) begin
            cyc();
            n++;
        end
        push(0, 1'b1, 8'h01); push(0, 1'b1, 8'h02);
        run_until_idle(100);
        chk_log("lock_order", exp_lock);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            tx_ready = rst ? 1'b0 : ($urandom_range(0, 2) != 0);
            hold = NREQ'($urandom & $urandom);
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 5) == 0 && pcount(i) < 16)
                    push(i, 1'($urandom_range(0, 1)), DW'($urandom));
            cyc();
        end
        rst = 1'b0; hold = '0; tx_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) push(i, 1'b1, DW'($urandom));
        run_until_idle(1000);
        chk("final_scoreboard_empty", eq_data.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
